// File: rtl/registers.sv
// RISC-V style integer register file: two combinational read ports, one
// synchronous write port, x0 hard-wired to zero, asynchronous clear.
module registers #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  regWrite,
    input  logic [ADDR_WIDTH-1:0] writeRegister,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic [ADDR_WIDTH-1:0] readRegister1,
    input  logic [ADDR_WIDTH-1:0] readRegister2,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // Entry 0 is never loaded, so it keeps its reset value of zero forever.
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (regWrite && (writeRegister == ADDR_WIDTH'(i))) begin
                regs_d[i] = writeData;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // No bypass: a same-cycle write becomes visible only after the edge.
    assign readData1 = regs_q[readRegister1];
    assign readData2 = regs_q[readRegister2];

endmodule

// File: tb/tb_registers.sv
// Self-checking bench for the register file: directed scenarios followed by
// randomized traffic compared against an array model of the 32 registers.
module tb_registers;

    logic        clk;
    logic        rst_n;
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic [4:0]  readRegister1;
    logic [4:0]  readRegister2;
    logic [31:0] readData1;
    logic [31:0] readData2;

    logic [31:0] model [32];
    int n_checks;
    int n_fail;

    registers dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .regWrite      (regWrite),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .readRegister1 (readRegister1),
        .readRegister2 (readRegister2),
        .readData1     (readData1),
        .readData2     (readData2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        regWrite      = 1'b1;
        writeRegister = addr;
        writeData     = data;
        @(posedge clk);
        if (rst_n && addr != 5'd0) model[addr] = data;
        #1;
        regWrite = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_model();
        rst_n = 1'b0;
        regWrite = 1'b0;
        writeRegister = '0;
        writeData = '0;
        readRegister1 = 5'd0;
        readRegister2 = 5'd1;

        // Reset state and reads held at zero while in reset
        #12;
        check("in_reset_rd1", readData1, 32'h0);
        check("in_reset_rd2", readData2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("after_reset_x0", readData1, 32'h0);
        check("after_reset_x1", readData2, 32'h0);

        // Write i to register i, then sweep read port 1
        for (int i = 0; i < 32; i++) write_reg(5'(i), 32'(i));
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            readRegister1 = 5'(i);
            #1;
            check("sweep_rd1", readData1, (i == 0) ? 32'h0 : 32'(i));
        end

        // x0 ignores writes
        write_reg(5'd0, 32'hFFFF_FFFF);
        readRegister1 = 5'd0;
        readRegister2 = 5'd0;
        #1;
        check("x0_rd1", readData1, 32'h0);
        check("x0_rd2", readData2, 32'h0);

        // Both ports on one register
        write_reg(5'd5, 32'hDEAD_BEEF);
        readRegister1 = 5'd5;
        readRegister2 = 5'd5;
        #1;
        check("same_addr_rd1", readData1, 32'hDEAD_BEEF);
        check("same_addr_rd2", readData2, 32'hDEAD_BEEF);

        // Read during write: old value before the edge, new value after
        write_reg(5'd7, 32'h11);
        @(negedge clk);
        readRegister1 = 5'd7;
        regWrite      = 1'b1;
        writeRegister = 5'd7;
        writeData     = 32'h22;
        #1;
        check("rdw_before", readData1, 32'h11);
        @(posedge clk);
        model[7] = 32'h22;
        #1;
        regWrite = 1'b0;
        check("rdw_after", readData1, 32'h22);

        // Disabled write leaves register alone
        write_reg(5'd3, 32'h1234_5678);
        @(negedge clk);
        regWrite      = 1'b0;
        writeRegister = 5'd3;
        writeData     = 32'hA5A5_A5A5;
        readRegister1 = 5'd3;
        @(posedge clk);
        #1;
        check("no_we_x3", readData1, 32'h1234_5678);

        // Asynchronous reset between edges, writes suppressed while held
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        check("async_rst_x3", readData1, 32'h0);
        readRegister2 = 5'd5;
        #1;
        check("async_rst_x5", readData2, 32'h0);
        regWrite      = 1'b1;
        writeRegister = 5'd3;
        writeData     = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        check("rst_blocks_wr", readData1, 32'h0);
        regWrite = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // First write after reset lands on the first enabled edge
        write_reg(5'd3, 32'hCAFE_F00D);
        check("first_wr_after_rst", readData1, 32'hCAFE_F00D);
        check("x5_cleared", readData2, 32'h0);

        // Randomized traffic with occasional mid-operation reset
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            regWrite      = 1'($urandom_range(0, 1));
            writeRegister = 5'($urandom_range(0, 31));
            writeData     = $urandom;
            readRegister1 = 5'($urandom_range(0, 31));
            readRegister2 = ($urandom_range(0, 3) == 0) ? writeRegister : 5'($urandom_range(0, 31));
            #1;
            check("rnd_pre_rd1", readData1, model[readRegister1]);
            check("rnd_pre_rd2", readData2, model[readRegister2]);
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 1'b0;
                clear_model();
                #1;
                check("rnd_rst_rd1", readData1, 32'h0);
                check("rnd_rst_rd2", readData2, 32'h0);
                #1;
                rst_n = 1'b1;
            end
            @(posedge clk);
            if (regWrite && writeRegister != 5'd0) model[writeRegister] = writeData;
            #1;
            check("rnd_post_rd1", readData1, model[readRegister1]);
            check("rnd_post_rd2", readData2, model[readRegister2]);
        end

        // Final full sweep of both ports
        @(negedge clk);
        regWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            readRegister1 = 5'(i);
            readRegister2 = 5'(31 - i);
            #1;
            check("final_rd1", readData1, model[i]);
            check("final_rd2", readData2, model[31 - i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
